mp3_stream_fifo: RTL

MP3_STREAM_FIFO -- requirements
Module: mp3_stream_fifo

---
 rtl/mp3_stream_pkg.sv | 21 ++
 rtl/mp3_fifo_ram.sv | 39 +++
 rtl/mp3_stream_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mp3_stream_pkg.sv
// -----------------------------------------------------------------------------
// mp3_stream_pkg
// Shared definitions for the MP3 byte-stream FIFO: packer state encoding,
// default FIFO depth, pad byte used to complete an odd-length stream, and the
// width of the popped-word counter.
// -----------------------------------------------------------------------------
package mp3_stream_pkg;

    // Byte packer states: waiting for high byte, waiting for low byte,
    // or flushing a lone high byte padded with PAD_BYTE.
    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_LO  = 2'd1,
        S_PAD = 2'd2
    } pack_state_e;

    localparam int unsigned DEFAULT_DEPTH_LOG2 = 6;
    localparam logic [7:0]  PAD_BYTE           = 8'h00;
    localparam int unsigned WORDS_OUT_W        = 32;

endpackage

// File: rtl/mp3_fifo_ram.sv
// -----------------------------------------------------------------------------
// mp3_fifo_ram
// Simple dual-port storage for the stream FIFO. Synchronous write, asynchronous
// read so the head word is visible right after the edge that wrote it. The
// array has no reset; validity is tracked by the FIFO pointers.
//
// Ports:
//   clk    in   write clock (rising edge)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational)
// -----------------------------------------------------------------------------
module mp3_fifo_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mp3_stream_fifo.sv
// -----------------------------------------------------------------------------
// mp3_stream_fifo
// Packs an MP3 byte stream big-endian into 16-bit words and buffers them in a
// show-ahead FIFO that feeds the decoder. An odd-length stream is completed by
// padding the final high byte with PAD_BYTE when EOS_I is seen.
//
// Ports:
//   CLK_I           in   clock, all logic on rising edge
//   RST_I           in   synchronous active-high reset (priority over FLUSH_I)
//   FLUSH_I         in   synchronous clear of stream state (keeps WORDS_OUT_O)
//   BYTE_DATA_I     in   stream byte
//   BYTE_VALID_I    in   BYTE_DATA_I valid
//   BYTE_READY_O    out  byte can be accepted this cycle
//   EOS_I           in   end-of-stream pulse
//   FIFO_DATA_O     out  head word (zero when empty)
//   FIFO_REN_I      in   pop strobe
//   FIFO_EMPTY_O    out  no word stored
//   ALMOST_EMPTY_O  out  LEVEL_O < AE_THRESH
//   LEVEL_O         out  stored word count
//   UNDERFLOW_O     out  sticky: pop attempted while empty
//   WORDS_OUT_O     out  popped word count, wraps
// -----------------------------------------------------------------------------
module mp3_stream_fifo
    import mp3_stream_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int unsigned AE_THRESH  = 8
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   FLUSH_I,
    input  logic [7:0]             BYTE_DATA_I,
    input  logic                   BYTE_VALID_I,
    output logic                   BYTE_READY_O,
    input  logic                   EOS_I,
    output logic [15:0]            FIFO_DATA_O,
    input  logic                   FIFO_REN_I,
    output logic                   FIFO_EMPTY_O,
    output logic                   ALMOST_EMPTY_O,
    output logic [DEPTH_LOG2:0]    LEVEL_O,
    output logic                   UNDERFLOW_O,
    output logic [WORDS_OUT_W-1:0] WORDS_OUT_O
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    pack_state_e state, state_nxt;

    logic [7:0]       held_byte, held_nxt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty;
    logic             wr_en, rd_en, ram_we;
    logic [15:0]      wr_word;
    logic [15:0]      ram_rdata;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

    assign rd_en = FIFO_REN_I && !empty;

    // Packer: next state, held byte, word write and byte ready.
    always_comb begin
        state_nxt    = state;
        held_nxt     = held_byte;
        wr_en        = 1'b0;
        wr_word      = '0;
        BYTE_READY_O = 1'b1;
        case (state)
            S_HI: begin
                // EOS here means an even byte count: nothing to pad.
                if (BYTE_VALID_I) begin
                    held_nxt  = BYTE_DATA_I;
                    state_nxt = S_LO;
                end
            end
            S_LO: begin
                BYTE_READY_O = !full;
                // A byte completing the word wins over a coincident EOS.
                if (BYTE_VALID_I && !full) begin
                    wr_en     = 1'b1;
                    wr_word   = {held_byte, BYTE_DATA_I};
                    state_nxt = S_HI;
                end else if (EOS_I) begin
                    state_nxt = S_PAD;
                end
            end
            S_PAD: begin
                BYTE_READY_O = 1'b0;
                if (!full) begin
                    wr_en     = 1'b1;
                    wr_word   = {held_byte, PAD_BYTE};
                    state_nxt = S_HI;
                end
            end
            default: begin
                state_nxt = S_HI;
            end
        endcase
    end

    // Storage writes are suppressed on reset/flush since the pointers are cleared.
    assign ram_we = wr_en && !RST_I && !FLUSH_I;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state       <= S_HI;
            held_byte   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            UNDERFLOW_O <= 1'b0;
            WORDS_OUT_O <= '0;
        end else if (FLUSH_I) begin
            state       <= S_HI;
            held_byte   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            UNDERFLOW_O <= 1'b0;
        end else begin
            state     <= state_nxt;
            held_byte <= held_nxt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                WORDS_OUT_O <= WORDS_OUT_O + WORDS_OUT_W'(1);
            end
            if (FIFO_REN_I && empty) begin
                UNDERFLOW_O <= 1'b1;
            end
        end
    end

    mp3_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (16)
    ) u_ram (
        .clk   (CLK_I),
        .we    (ram_we),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (wr_word),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

    assign FIFO_EMPTY_O   = empty;
    assign FIFO_DATA_O    = empty ? 16'h0000 : ram_rdata;
    assign LEVEL_O        = wr_ptr - rd_ptr;
    assign ALMOST_EMPTY_O = (32'(LEVEL_O) < AE_THRESH);

endmodule
